// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module rca_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             carry,
   output logic             c_top
);
   genvar i;
   generate
      for (i = 0; i < CHUNK; i++) begin : g_fa
         logic ci;
         logic co;
         if (i == 0) begin : g_first
            assign ci = cin;
         end else begin : g_next
            assign ci = g_fa[i-1].co;
         end
         assign sum[i] = a[i] ^ b[i] ^ ci;
         assign co     = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
      end
   endgenerate

   assign carry = g_fa[CHUNK-1].co;
   assign c_top = g_fa[CHUNK-1].ci;
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, WIDTH/CHUNK cycles latency.
// Per-stage valid/ready: a stage loads when empty or draining, so bubbles collapse and a stall holds the outputs.
module pipelined_rca #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);
   localparam int STAGES = (CHUNK > 0) ? WIDTH / CHUNK : 1;
   localparam int LAST   = STAGES - 1;

   generate
      if ((CHUNK < 1) || ((WIDTH % ((CHUNK > 0) ? CHUNK : 1)) != 0)) begin : g_bad_cfg
         $error("pipelined_rca: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   logic [STAGES-1:0] v_q, c_q, v_in, c_in, cout, ctop, rdy;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  s_q   [STAGES];
   logic [WIDTH-1:0]  a_in  [STAGES];
   logic [WIDTH-1:0]  b_in  [STAGES];
   logic [WIDTH-1:0]  s_in  [STAGES];
   logic [WIDTH-1:0]  s_nxt [STAGES];
   logic [CHUNK-1:0]  csum  [STAGES];
   logic              ovf_q;
   logic              unused_ctop;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         // A stage can take data if any stage from here to the output is free, or the output drains.
         assign rdy[k] = out_ready | ~(&v_q[LAST:k]);

         if (k == 0) begin : g_head
            // Subtraction is a + ~b + 1: invert b up front and force the first carry.
            assign a_in[k] = a;
            assign b_in[k] = b ^ {WIDTH{sub}};
            assign s_in[k] = '0;
            assign c_in[k] = sub | cin;
            assign v_in[k] = in_valid;
         end else begin : g_body
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign v_in[k] = v_q[k-1];
         end

         rca_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (a_in[k][k*CHUNK +: CHUNK]),
            .b     (b_in[k][k*CHUNK +: CHUNK]),
            .cin   (c_in[k]),
            .sum   (csum[k]),
            .carry (cout[k]),
            .c_top (ctop[k])
         );
      end
   endgenerate

   always_comb begin
      for (int j = 0; j < STAGES; j++) begin
         s_nxt[j] = s_in[j];
         s_nxt[j][j*CHUNK +: CHUNK] = csum[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int j = 0; j < STAGES; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
            s_q[j] <= '0;
         end
      end else begin
         for (int j = 0; j < STAGES; j++) begin
            if (rdy[j]) begin
               v_q[j] <= v_in[j];
               if (v_in[j]) begin
                  a_q[j] <= a_in[j];
                  b_q[j] <= b_in[j];
                  s_q[j] <= s_nxt[j];
                  c_q[j] <= cout[j];
               end
            end
         end
         if (rdy[LAST] && v_in[LAST]) begin
            ovf_q <= ctop[LAST] ^ cout[LAST];
         end
      end
   end

   // Only the last slice's top-bit carry matters for overflow.
   assign unused_ctop = ^ctop;

   assign in_ready  = rdy[0];
   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign carry     = c_q[LAST];
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca (WIDTH=16, CHUNK=4): directed table, stall, random and reset cases.
module tb_pipelined_rca;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         carry;
   logic         overflow;

   always #5 clk = ~clk;

   pipelined_rca #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow)
   );

   typedef struct packed {
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] esum;
      logic         ecarry;
      logic         eovf;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_out = 0;
   res_t exp_q[$];

   // Reference: plain integer arithmetic on the operand values.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic s);
      res_t r;
      int   ua, ub, sa, sb, full, sres;
      ua = int'(x);
      ub = int'(y);
      sa = int'($signed(x));
      sb = int'($signed(y));
      if (s) begin
         full    = ua - ub;
         sres    = sa - sb;
         r.carry = (ua >= ub);
      end else begin
         full    = ua + ub + int'(ci);
         sres    = sa + sb + int'(ci);
         r.carry = (full >= 65536);
      end
      r.sum = full[W-1:0];
      r.ovf = (sres > 32767) || (sres < -32768);
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      res_t e;
      if (rst_n) begin
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_spurious: output %h with nothing outstanding", sum);
            end else begin
               e = exp_q.pop_front();
               check("sb_sum", 32'(sum), 32'(e.sum));
               check("sb_carry", 32'(carry), 32'(e.carry));
               check("sb_ovf", 32'(overflow), 32'(e.ovf));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t         tbl[10];
      logic [W-1:0] va[6], vb[6];
      logic [W-1:0] hold_sum;
      logic         hold_c, hold_o, fired;
      int           lat, acc, idx, cyc, base;

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[4] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
      tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[6] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[8] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
      tbl[9] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

      // Reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_carry", 32'(carry), 0);
      check("rst_ovf", 32'(overflow), 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 1);

      // Directed vectors, one at a time, latency measured from the accepting cycle
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
         in_valid = 1'b1;
         check("tbl_in_ready", 32'(in_ready), 1);
         tick();
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin
            tick();
            lat++;
         end
         check("tbl_latency", 32'(lat), 4);
         check("tbl_sum", 32'(sum), 32'(tbl[i].esum));
         check("tbl_carry", 32'(carry), 32'(tbl[i].ecarry));
         check("tbl_ovf", 32'(overflow), 32'(tbl[i].eovf));
      end

      // Back-to-back burst: one transfer per cycle
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         a = 16'($urandom); b = 16'($urandom);
         cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) acc++;
      end
      tick();
      in_valid = 1'b0;
      check("burst_accepted", 32'(acc), 8);
      repeat (8) tick();
      check("burst_drained", 32'(exp_q.size()), 0);

      // Stall: six offered with output blocked, four fit
      for (int i = 0; i < 6; i++) begin
         va[i] = 16'($urandom);
         vb[i] = 16'($urandom);
      end
      base = n_out;
      out_ready = 1'b0;
      idx = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (idx < 6) begin
            in_valid = 1'b1; a = va[idx]; b = vb[idx]; sub = idx[0]; cin = idx[1];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
      end
      check("stall_accepted", 32'(idx), 4);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_valid", 32'(out_valid), 1);
      hold_sum = sum; hold_c = carry; hold_o = overflow;
      repeat (3) @(negedge clk);
      check("stall_sum_stable", 32'(sum), 32'(hold_sum));
      check("stall_carry_stable", 32'(carry), 32'(hold_c));
      check("stall_ovf_stable", 32'(overflow), 32'(hold_o));
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("full_pass_in_ready", 32'(in_ready), 1);
      cyc = 0;
      while (idx < 6 && cyc < 40) begin
         if (in_valid && in_ready) idx++;
         tick();
         cyc++;
         if (idx < 6) begin
            in_valid = 1'b1; a = va[idx]; b = vb[idx]; sub = idx[0]; cin = idx[1];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 40) begin
         tick();
         cyc++;
      end
      check("stall_all_out", 32'(n_out - base), 6);
      check("stall_drained", 32'(exp_q.size()), 0);

      // Random traffic with out_ready toggling every cycle
      base = n_out;
      acc = 0;
      cyc = 0;
      fired = 1'b0;
      in_valid = 1'b0;
      while (acc < 1000 && cyc < 10000) begin
         tick();
         cyc++;
         out_ready = ~out_ready;
         if (!in_valid || fired) begin
            in_valid = ($urandom_range(3) != 0);
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
         end
         @(negedge clk);
         fired = in_valid && in_ready;
         if (fired) acc++;
      end
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 50) begin
         tick();
         cyc++;
      end
      check("rnd_accepted", 32'(acc), 1000);
      check("rnd_delivered", 32'(n_out - base), 1000);
      check("rnd_drained", 32'(exp_q.size()), 0);

      // Reset with three transactions in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'b0; cin = 1'b0;
      end
      tick();
      in_valid = 1'b0;
      tick();
      check("pre_rst_out_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_sum", 32'(sum), 0);
      exp_q.delete();
      base = n_out;
      repeat (2) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 1);
      repeat (20) tick();
      check("post_rst_nothing_out", 32'(n_out - base), 0);
      tick();
      in_valid = 1'b1; a = 16'h1234; b = 16'h0235; sub = 1'b1; cin = 1'b0;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("post_rst_new_out", 32'(n_out - base), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per pipeline stage; WIDTH divisible by CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port cin  input  1  carry-in, add mode only.
REQ-009 SHALL have port sub  input  1  0 = a+b+cin, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port carry  output  1  carry-out of MSB (sub: 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  signed two's-complement overflow.

Function
REQ-015 SHALL transfer input when in_valid & in_ready, output when out_valid & out_ready.
REQ-016 sub=1 SHALL compute a + ~b + 1, ignoring cin.
REQ-017 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] using carry registered by stage k-1 (stage 0: cin or sub), registering partial sum, carry, valid, and remaining operand bits.
REQ-018 No combinational carry path SHALL span more than CHUNK bits.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with out_ready held high.
REQ-020 Throughput SHALL be one transaction per cycle with out_ready high.
REQ-021 A stage SHALL load when empty or when its content moves on that cycle; otherwise it holds.
REQ-022 in_ready SHALL equal (stage 0 empty) OR (stage 0 advancing); no combinational path from in_valid to in_ready.
REQ-023 With out_valid high and out_ready low, sum/carry/overflow SHALL remain stable until transfer.
REQ-024 Full pipeline (STAGES entries) with out_ready low SHALL drive in_ready low; no transaction lost or duplicated.
REQ-025 Simultaneous output and input transfer on full pipeline SHALL keep occupancy constant.
REQ-026 overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-027 Results SHALL leave in acceptance order.
REQ-028 sum SHALL be WIDTH bits, modulo 2^WIDTH; carry is bit WIDTH.

Reset
REQ-029 rst_n low SHALL asynchronously clear all stage valid bits; out_valid=0, sum=0, carry=0, overflow=0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; none emerge afterwards.
REQ-032 Data registers need not be reset except those driving outputs.

Structure
REQ-033 No shared package SHALL be required; STAGES SHALL be a localparam derived from WIDTH/CHUNK.
REQ-034 One sub-module SHALL be used: rca_chunk, a combinational CHUNK-bit ripple adder (a, b, cin -> sum, carry, carry into top bit), built from fa cells, instantiated STAGES times via generate.
REQ-035 Elaboration SHALL fail when WIDTH mod CHUNK != 0 or CHUNK < 1.

Verification (WIDTH=16, CHUNK=4)
REQ-036 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0000, carry=1, overflow=0.
REQ-037 a=0x7FFF, b=0x0001, add -> sum=0x8000, carry=0, overflow=1; a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry=0, overflow=0.
REQ-038 out_ready=0, push 6 back-to-back -> exactly 4 accepted, in_ready low, outputs stable; then out_ready=1 -> all 6 emerge in order, correct values.
REQ-039 out_ready toggled every cycle, 1000 random transfers with random sub/cin -> scoreboard exact match, no loss or duplication.
REQ-040 rst_n low while 3 transactions in flight -> out_valid=0 immediately; after release nothing emerges until new input; in_ready=1.
